// File: rtl/chunk_buffer_bridge.sv
// Sample-stream side of the chunk memory interface: double-banked capture buffer,
// random-access processor ports, and paced playback of the processed chunk.
module chunk_buffer_bridge #(
    parameter int SAMPLE_SIZE      = 24,
    parameter int IO_BUFF_SIZE     = 64,
    parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SAMPLE_SIZE-1:0]      in_sample,
    input  logic                        in_valid,
    output logic [SAMPLE_SIZE-1:0]      out_sample,
    output logic                        out_valid,
    output logic                        chunk_pulse,
    input  logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr,
    output logic [SAMPLE_SIZE-1:0]      input_buff_sample,
    input  logic [IO_BUFF_PTR_BITS-1:0] output_buff_ptr,
    input  logic [SAMPLE_SIZE-1:0]      output_buff_sample,
    input  logic                        output_buff_write_pulse,
    output logic                        overrun
);
    localparam int CNT_W = IO_BUFF_PTR_BITS + 1;
    localparam logic [CNT_W-1:0]            FULL = CNT_W'(IO_BUFF_SIZE);
    localparam logic [IO_BUFF_PTR_BITS-1:0] LAST = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

    logic [SAMPLE_SIZE-1:0] in_mem  [2][IO_BUFF_SIZE];
    logic [SAMPLE_SIZE-1:0] out_mem [2][IO_BUFF_SIZE];

    logic                        bank;
    logic                        nbank;
    logic [IO_BUFF_PTR_BITS-1:0] wr_ptr;
    logic [CNT_W-1:0]            wr_count;
    logic [CNT_W-1:0]            wr_count_nxt;
    logic                        primed;
    logic                        primed_once;
    logic                        swap;

    assign nbank = ~bank;
    assign swap  = in_valid && (wr_ptr == LAST);

    // A write landing on the swap edge still belongs to the chunk being closed.
    always_comb begin
        wr_count_nxt = wr_count;
        if (output_buff_write_pulse && (wr_count != FULL))
            wr_count_nxt = wr_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (in_valid)
            in_mem[bank][wr_ptr] <= in_sample;
        if (output_buff_write_pulse)
            out_mem[nbank][output_buff_ptr] <= output_buff_sample;
    end

    assign input_buff_sample = in_mem[nbank][input_buff_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank        <= 1'b0;
            wr_ptr      <= '0;
            wr_count    <= '0;
            primed      <= 1'b0;
            primed_once <= 1'b0;
            chunk_pulse <= 1'b0;
            out_valid   <= 1'b0;
            out_sample  <= '0;
            overrun     <= 1'b0;
        end else begin
            chunk_pulse <= swap;
            out_valid   <= in_valid;
            if (in_valid) begin
                out_sample <= primed ? out_mem[bank][wr_ptr] : '0;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (swap) begin
                bank        <= nbank;
                wr_count    <= '0;
                primed_once <= 1'b1;
                // Playback holds real data only once a full chunk has been processed.
                if (primed_once) begin
                    primed <= 1'b1;
                    if (wr_count_nxt != FULL)
                        overrun <= 1'b1;
                end
            end else begin
                wr_count <= wr_count_nxt;
            end
        end
    end
endmodule

// File: tb/tb_chunk_buffer_bridge.sv
// Scoreboard bench for chunk_buffer_bridge: driver pushes expected playback and
// chunk-pulse cycles, a monitor pops and compares; a model processor runs alongside.
module tb_chunk_buffer_bridge;
    localparam int SS = 24;
    localparam int N  = 64;
    localparam int PB = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [SS-1:0] in_sample;
    logic          in_valid;
    logic [SS-1:0] out_sample;
    logic          out_valid;
    logic          chunk_pulse;
    logic [PB-1:0] input_buff_ptr;
    logic [SS-1:0] input_buff_sample;
    logic [PB-1:0] output_buff_ptr;
    logic [SS-1:0] output_buff_sample;
    logic          output_buff_write_pulse;
    logic          overrun;

    chunk_buffer_bridge #(.SAMPLE_SIZE(SS), .IO_BUFF_SIZE(N)) dut (
        .clk(clk), .rst(rst),
        .in_sample(in_sample), .in_valid(in_valid),
        .out_sample(out_sample), .out_valid(out_valid),
        .chunk_pulse(chunk_pulse),
        .input_buff_ptr(input_buff_ptr), .input_buff_sample(input_buff_sample),
        .output_buff_ptr(output_buff_ptr), .output_buff_sample(output_buff_sample),
        .output_buff_write_pulse(output_buff_write_pulse),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int            nvec = 0;
    int            nerr = 0;
    int            cyc  = 0;
    int            nstrobe = 0;
    int            drv_idx = 0;
    int            proc_mode = 0;   // 0 off, 1 copy, 2 short chunk 2, 3 last write on swap edge
    logic [SS-1:0] exp_q [$];
    int            pulse_q [$];
    int            pend [$];
    logic [SS-1:0] sent [512];
    logic [SS-1:0] pb [2][N];       // what the processor has placed in each output bank

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_one(input logic [SS-1:0] d);
        @(negedge clk);
        in_sample = d;
        in_valid  = 1'b1;
        drv_idx   = nstrobe % N;
        sent[nstrobe] = d;
        exp_q.push_back((nstrobe >= 2*N) ? pb[(nstrobe/N)%2][nstrobe%N] : '0);
        if (nstrobe % N == N-1) pulse_q.push_back(cyc + 1);
        nstrobe++;
    endtask

    task automatic run(input int n, input int gap, input logic [SS-1:0] base);
        for (int i = 0; i < n; i++) begin
            drive_one(base + SS'(nstrobe));
            if (gap > 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (gap-2) @(negedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush();
        exp_q.delete();
        pulse_q.delete();
        pend.delete();
        nstrobe = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        flush();
        idle(2);
        rst = 1'b0;
    endtask

    task automatic drained(input string tag);
        chk({tag, "_exp_q_left"}, exp_q.size(), 0);
        chk({tag, "_pulse_q_left"}, pulse_q.size(), 0);
    endtask

    // Monitor
    initial begin
        logic [SS-1:0] e;
        int            ec;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL out_unexpected: got out_valid with sample %0h, expected none", out_sample);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_sample", out_sample, e);
                    end
                end
                if (chunk_pulse) begin
                    if (pulse_q.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL chunk_pulse_unexpected: got pulse at cycle %0d, expected none", cyc);
                    end else begin
                        ec = pulse_q.pop_front();
                        chk("chunk_pulse_cycle", cyc, ec);
                    end
                end
            end
        end
    end

    always @(negedge clk)
        if (chunk_pulse && !rst && proc_mode != 0) pend.push_back(nstrobe/N - 1);

    // Model processor: reads the finished input chunk, copies it to the output bank.
    initial begin
        int            c;
        int            n;
        logic [SS-1:0] d;
        forever begin
            @(negedge clk);
            if (pend.size() != 0) begin
                c = pend.pop_front();
                n = (proc_mode == 3 || (proc_mode == 2 && c == 2)) ? N-1 : N;
                for (int i = 0; i < n; i++) begin
                    @(negedge clk);
                    input_buff_ptr = PB'(i);
                    #1;
                    d = input_buff_sample;
                    chk("in_read", d, sent[c*N + i]);
                    output_buff_ptr         = PB'(i);
                    output_buff_sample      = d;
                    output_buff_write_pulse = 1'b1;
                    pb[c%2][i] = d;
                end
                @(negedge clk);
                output_buff_write_pulse = 1'b0;
                if (proc_mode == 3) begin
                    #2;
                    while (proc_mode == 3 && !(in_valid && drv_idx == N-1)) begin
                        @(negedge clk);
                        #2;
                    end
                    if (proc_mode == 3) begin
                        output_buff_ptr         = PB'(N-1);
                        output_buff_sample      = 24'hABCDEF;
                        output_buff_write_pulse = 1'b1;
                        pb[c%2][N-1] = 24'hABCDEF;
                        @(negedge clk);
                        output_buff_write_pulse = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        input_buff_ptr = '0;
        output_buff_ptr = '0;
        output_buff_sample = '0;
        output_buff_write_pulse = 1'b0;
        idle(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_chunk_pulse", chunk_pulse, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Chunk pulse, input reads and loopback over four chunks of ramp 1,2,3...
        proc_mode = 1;
        run(4*N, 4, 24'h000001);
        idle(80);
        chk("loop_overrun", overrun, 0);
        drained("loop");

        // Processor writes only 63 samples of chunk 2
        do_reset();
        proc_mode = 2;
        run(4*N-1, 4, 24'h100000);
        idle(4);
        chk("ovr_before", overrun, 0);
        run(1, 4, 24'h100000);
        idle(2);
        chk("ovr_rise", overrun, 1);
        run(2*N, 4, 24'h100000);
        idle(80);
        chk("ovr_sticky", overrun, 1);
        drained("ovr");

        // Last processor write coincides with the swap strobe
        do_reset();
        chk("swp_ovr_cleared", overrun, 0);
        proc_mode = 3;
        run(4*N, 4, 24'h200000);
        idle(80);
        chk("swp_overrun", overrun, 0);
        proc_mode = 0;
        idle(4);
        drained("swp");

        // Asynchronous reset mid-chunk while in_valid is high
        do_reset();
        run(30, 4, 24'h400000);
        drive_one(24'h4FFFFF);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("amid_out_valid", out_valid, 0);
        chk("amid_out_sample", out_sample, 0);
        chk("amid_chunk_pulse", chunk_pulse, 0);
        chk("amid_overrun", overrun, 0);
        flush();
        @(negedge clk);
        in_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        run(N+5, 4, 24'h410000);
        idle(10);
        drained("amid");

        // Continuous in_valid; nothing written by the processor
        do_reset();
        run(200, 1, 24'h300000);
        idle(4);
        chk("b2b_overrun", overrun, 1);
        drained("b2b");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
